// File: rtl/ahb_master_arbiter_pkg.sv
// Shared types for the AHB-Lite master arbiter: HTRANS encoding, arbiter states,
// hold-counter width and the master-index width helper.
package ahb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 1'b0;
    localparam arb_state_t ARB_OWN  = 1'b1;

    localparam int DEFAULT_NUM_MASTERS = 3;
    localparam int HOLD_CNT_W          = 8;

    // Width of a master index; never narrower than one bit.
    function automatic int MST_IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Master-side bus bundle of the arbiter. The slave modport is the arbiter's view;
// the master modport is the view of whatever drives the master requests.
interface ahb_master_arbiter_if #(
    parameter int NUM_MASTERS = ahb_master_arbiter_pkg::DEFAULT_NUM_MASTERS
);
    import ahb_master_arbiter_pkg::*;

    localparam int IDX_W = MST_IDX_W(NUM_MASTERS);

    HTRANS_state            mst_HTRANS [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] mst_HLOCK;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       HMASTER;
    logic [IDX_W-1:0]       data_owner;
    logic                   data_valid;
    logic [NUM_MASTERS-1:0] mst_HREADY;

    modport master (
        output mst_HTRANS, mst_HLOCK, HREADY,
        input  grant, HMASTER, data_owner, data_valid, mst_HREADY
    );

    modport slave (
        input  mst_HTRANS, mst_HLOCK, HREADY,
        output grant, HMASTER, data_owner, data_valid, mst_HREADY
    );

endinterface

// File: rtl/ahb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after i_start,
// wrapping modulo NUM_MASTERS, with masters in i_excl skipped.
module ahb_master_arbiter_rr_pick
    import ahb_master_arbiter_pkg::*;
#(
    parameter int   NUM_MASTERS = DEFAULT_NUM_MASTERS,
    localparam int  IDX_W       = MST_IDX_W(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_start,
    input  logic [NUM_MASTERS-1:0] i_excl,
    output logic [IDX_W-1:0]       o_winner,
    output logic                   o_found
);

    logic [NUM_MASTERS-1:0] w_elig;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
            assign w_elig[gi] = i_req[gi] & ~i_excl[gi];
        end
    endgenerate

    // Scan from the farthest offset down so the closest eligible master wins last.
    always_comb begin
        logic [IDX_W:0] w_sum;
        o_winner = '0;
        o_found  = 1'b0;
        w_sum    = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_start} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_MASTERS)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_MASTERS);
            end
            if (w_elig[w_sum[IDX_W-1:0]]) begin
                o_winner = w_sum[IDX_W-1:0];
                o_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite master arbiter with separate address/data-phase ownership.
// Define ARB_HOLD_LIMIT_EN to build the beat counter and forced release after MAX_HOLD beats.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int MAX_HOLD    = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_master_arbiter_if.slave bus
);

    localparam int               IDX_W    = MST_IDX_W(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             r_state, w_state_next;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_hmaster;
    logic [IDX_W-1:0]       r_last_owner;
    logic [IDX_W-1:0]       r_data_owner;
    logic                   r_data_valid;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_owner_onehot;
    logic [NUM_MASTERS-1:0] w_winner_onehot;
    logic [NUM_MASTERS-1:0] w_pick_excl;
    logic [IDX_W-1:0]       w_pick_start;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_found;
    HTRANS_state            w_own_trans;
    logic                   w_own_active;
    logic                   w_others;
    logic                   w_forced;
    logic                   w_release;
    logic                   w_acquire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_per_master
            assign w_req[gi]           = (bus.mst_HTRANS[gi] != IDLE);
            assign w_owner_onehot[gi]  = (r_hmaster == IDX_W'(gi));
            assign w_winner_onehot[gi] = (w_winner == IDX_W'(gi));
            assign bus.mst_HREADY[gi]  = bus.HREADY &
                (r_grant[gi] | (r_data_valid & (r_data_owner == IDX_W'(gi))));
        end
    endgenerate

    assign w_own_trans  = bus.mst_HTRANS[r_hmaster];
    assign w_own_active = (r_state == ARB_OWN) && ((w_own_trans == NONSEQ) || (w_own_trans == SEQ));
    assign w_others     = |(w_req & ~w_owner_onehot);

`ifdef ARB_HOLD_LIMIT_EN
    logic [HOLD_CNT_W-1:0] r_count;
    logic                  w_at_limit;
    logic                  w_boundary;

    // A burst boundary at the limit either hands the bus over or, if nobody waits, restarts the count.
    assign w_at_limit = (r_count == HOLD_CNT_W'(MAX_HOLD));
    assign w_boundary = (r_state == ARB_OWN) && w_at_limit && (w_own_trans == NONSEQ) &&
                        !bus.mst_HLOCK[r_hmaster];
    assign w_forced   = w_boundary && w_others;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_count <= '0;
        end else if (bus.HREADY) begin
            if (w_release || w_boundary) begin
                r_count <= '0;
            end else if (w_own_active && !w_at_limit) begin
                r_count <= r_count + HOLD_CNT_W'(1);
            end
        end
    end
`else
    logic w_unused_hold;
    assign w_unused_hold = ^{bus.mst_HLOCK, HOLD_CNT_W'(MAX_HOLD)};
    assign w_forced      = 1'b0;
`endif

    assign w_release    = bus.HREADY && (r_state == ARB_OWN) && ((w_own_trans == IDLE) || w_forced);
    assign w_pick_excl  = w_forced ? w_owner_onehot : '0;
    assign w_pick_start = (r_last_owner == LAST_IDX) ? '0 : r_last_owner + IDX_W'(1);
    assign w_acquire    = bus.HREADY && ((r_state == ARB_IDLE) || w_release) && w_found;

    ahb_master_arbiter_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_pick (
        .i_req    (w_req),
        .i_start  (w_pick_start),
        .i_excl   (w_pick_excl),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    always_comb begin
        w_state_next = r_state;
        if (bus.HREADY) begin
            if (r_state == ARB_IDLE) begin
                if (w_found) begin
                    w_state_next = ARB_OWN;
                end
            end else if (w_release) begin
                w_state_next = w_found ? ARB_OWN : ARB_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_hmaster    <= '0;
            r_last_owner <= LAST_IDX;
            r_data_owner <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_acquire) begin
                r_hmaster    <= w_winner;
                r_last_owner <= w_winner;
                r_grant      <= w_winner_onehot;
            end else if (w_release) begin
                r_grant <= '0;
            end
            // The outgoing owner's last beat completes here, which is what makes handover gapless.
            if (bus.HREADY) begin
                r_data_owner <= r_hmaster;
                r_data_valid <= w_own_active;
            end
        end
    end

    assign bus.grant      = r_grant;
    assign bus.HMASTER    = r_hmaster;
    assign bus.data_owner = r_data_owner;
    assign bus.data_valid = r_data_valid;

endmodule
